key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_pkg.sv | 49 ++++
 rtl/row_sync.sv | 23 ++
 rtl/key_scan.sv | 156 +++++++++++++++
 tb/tb_key_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package key_scan_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned KEYS   = ROWS * COLS;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_PRESSED,
        ST_RELEASE_DB
    } state_t;

    typedef enum logic [1:0] {
        SNAP_NONE,
        SNAP_SINGLE,
        SNAP_MULTI
    } snap_class_t;

    // Classify a full-keypad snapshot by how many keys read as pressed.
    function automatic snap_class_t classify(input logic [KEYS-1:0] snap);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < KEYS; i++) begin
            n = n + 5'(snap[i]);
        end
        if (n == 5'd0) begin
            return SNAP_NONE;
        end else if (n == 5'd1) begin
            return SNAP_SINGLE;
        end
        return SNAP_MULTI;
    endfunction

    // Index of the lowest set bit; only meaningful for a SINGLE snapshot.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [KEYS-1:0] snap);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (snap[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-stage synchronizer for the asynchronous keypad row lines; idles high.
module row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: column drive, row sampling, snapshot debounce and key report.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES    = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_,
    output logic [3:0] col_select_,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DWELL_W = 16;
    localparam int unsigned CNT_W   = 4;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DB_TARGET  = CNT_W'(DEBOUNCE_SCANS);

    logic [ROWS-1:0]    row_q;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         column;
    logic [KEYS-1:0]    snap_acc;
    logic [KEYS-1:0]    snap_full;
    logic               sample_now;
    logic               scan_done;
    snap_class_t        snap_cls;
    logic [CODE_W-1:0]  snap_code;

    state_t             state;
    logic [CNT_W-1:0]   db_count;
    logic [CNT_W-1:0]   db_count_inc;
    logic [CODE_W-1:0]  candidate;

    row_sync #(.WIDTH(ROWS)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_),
        .q     (row_q)
    );

    // Snapshot as it stands once the currently driven column is folded in.
    always_comb begin
        sample_now   = (dwell == DWELL_LAST);
        scan_done    = sample_now && (column == 2'd3);
        snap_full    = snap_acc;
        for (int r = 0; r < ROWS; r++) begin
            snap_full[{2'(r), column}] = ~row_q[r];
        end
        snap_cls     = classify(snap_full);
        snap_code    = lowest_index(snap_full);
        db_count_inc = (db_count == '1) ? db_count : db_count + 4'd1;
    end

    // Free-running column scan, independent of the key FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell       <= '0;
            column      <= 2'd0;
            col_select_ <= 4'b1110;
            snap_acc    <= '0;
        end else if (sample_now) begin
            dwell       <= '0;
            column      <= column + 2'd1;
            col_select_ <= ~(4'b0001 << (column + 2'd1));
            snap_acc    <= snap_full;
        end else begin
            dwell       <= dwell + 16'd1;
        end
    end

    // Press/release debounce; only moves on a completed scan.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            db_count  <= '0;
            candidate <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    ST_IDLE: begin
                        if (snap_cls == SNAP_SINGLE) begin
                            candidate <= snap_code;
                            if (DB_TARGET <= 4'd1) begin
                                state     <= ST_PRESSED;
                                db_count  <= '0;
                                key_code  <= snap_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state    <= ST_PRESS_DB;
                                db_count <= 4'd1;
                            end
                        end
                    end
                    ST_PRESS_DB: begin
                        if (snap_cls == SNAP_SINGLE && snap_code == candidate) begin
                            if (db_count_inc >= DB_TARGET) begin
                                state     <= ST_PRESSED;
                                db_count  <= '0;
                                key_code  <= candidate;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                db_count <= db_count_inc;
                            end
                        end else if (snap_cls == SNAP_SINGLE) begin
                            candidate <= snap_code;
                            db_count  <= 4'd1;
                        end else begin
                            state    <= ST_IDLE;
                            db_count <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (snap_cls == SNAP_NONE) begin
                            if (DB_TARGET <= 4'd1) begin
                                state    <= ST_IDLE;
                                db_count <= '0;
                                key_held <= 1'b0;
                            end else begin
                                state    <= ST_RELEASE_DB;
                                db_count <= 4'd1;
                            end
                        end
                    end
                    ST_RELEASE_DB: begin
                        if (snap_cls == SNAP_NONE) begin
                            if (db_count_inc >= DB_TARGET) begin
                                state    <= ST_IDLE;
                                db_count <= '0;
                                key_held <= 1'b0;
                            end else begin
                                db_count <= db_count_inc;
                            end
                        end else begin
                            state    <= ST_PRESSED;
                            db_count <= '0;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        db_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a behavioural keypad driven from col_select_.
module tb_key_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_;
    logic [3:0]  col_select_;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'h0000;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          vcount   = 0;
    int          vcyc     = 0;
    logic [3:0]  vcode    = 4'h0;

    always #5 clock = ~clock;

    key_scan #(
        .SCAN_CYCLES    (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .row_        (row_),
        .col_select_ (col_select_),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_ = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col_select_[c]) begin
                    row_[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
            if (key_valid === 1'b1) begin
                vcount++;
                vcyc  = cyc;
                vcode = key_code;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic do_reset();
        int v0;
        reset = 1'b1;
        v0    = vcount;
        tick(2);
        check("rst_no_valid", vcount, v0);
        check("rst_col", col_select_, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        reset  = 1'b0;
        cyc    = 0;
        vcount = 0;
        vcyc   = 0;
    endtask

    initial begin
        int held_low;
        int bad_shape;
        int bad_len;
        int bad_order;
        int trans;
        int run;
        logic [3:0] prev;

        // Stable press of key 6: accepted one cycle after the 3rd scan (edge 48).
        tick(1);
        do_reset();
        pressed = 16'h0040;
        run_to(47);
        check("t1_no_early", vcount, 0);
        run_to(48);
        check("t1_valid", key_valid, 1'b1);
        check("t1_cycle", vcyc, 48);
        check("t1_code", key_code, 4'h6);
        check("t1_held", key_held, 1'b1);
        run_to(49);
        check("t1_pulse_1cyc", key_valid, 1'b0);
        run_to(96);
        check("t1_one_report", vcount, 1);

        // Bounce: pressed 1 scan, released 1, then pressed 3 scans.
        do_reset();
        pressed = 16'h0040;
        run_to(16);
        pressed = 16'h0000;
        run_to(32);
        pressed = 16'h0040;
        run_to(79);
        check("t2_no_early", vcount, 0);
        run_to(80);
        check("t2_count", vcount, 1);
        check("t2_code", vcode, 4'h6);
        run_to(120);
        check("t2_single_report", vcount, 1);

        // Keys 3 and 9 together are ignored; dropping 9 accepts 3.
        do_reset();
        pressed = 16'h0208;
        run_to(160);
        check("t3_multi_none", vcount, 0);
        check("t3_multi_held", key_held, 1'b0);
        pressed = 16'h0008;
        run_to(207);
        check("t3_no_early", vcount, 0);
        run_to(208);
        check("t3_count", vcount, 1);
        check("t3_code", key_code, 4'h3);

        // Key 15: short release is swallowed, full release drops key_held.
        do_reset();
        pressed = 16'h8000;
        run_to(48);
        check("t4_count", vcount, 1);
        check("t4_code", key_code, 4'hF);
        pressed  = 16'h0000;
        held_low = 0;
        while (cyc < 80) begin
            tick(1);
            if (key_held !== 1'b1) held_low++;
        end
        pressed = 16'h8000;
        while (cyc < 128) begin
            tick(1);
            if (key_held !== 1'b1) held_low++;
        end
        check("t4_held_through", held_low, 0);
        check("t4_no_second", vcount, 1);
        pressed = 16'h0000;
        run_to(175);
        check("t4_held_before_rel", key_held, 1'b1);
        run_to(176);
        check("t4_released", key_held, 1'b0);
        check("t4_no_rel_report", vcount, 1);

        // Key 0 with reset mid-debounce: needs three fresh scans afterwards.
        do_reset();
        pressed = 16'h0001;
        run_to(20);
        check("t5_pre_reset", vcount, 0);
        do_reset();
        run_to(47);
        check("t5_no_early", vcount, 0);
        run_to(48);
        check("t5_valid", key_valid, 1'b1);
        check("t5_count", vcount, 1);
        check("t5_code", vcode, 4'h0);

        // Column drive shape and dwell over 1000 cycles.
        pressed = 16'h0000;
        do_reset();
        bad_shape = 0;
        bad_len   = 0;
        bad_order = 0;
        trans     = 0;
        run       = 1;
        prev      = col_select_;
        repeat (1000) begin
            tick(1);
            if (col_select_ != 4'b1110 && col_select_ != 4'b1101 &&
                col_select_ != 4'b1011 && col_select_ != 4'b0111) bad_shape++;
            if (col_select_ == prev) begin
                run++;
            end else begin
                trans++;
                if (run != 4) bad_len++;
                if (col_select_ != {prev[2:0], prev[3]}) bad_order++;
                run = 1;
            end
            prev = col_select_;
        end
        check("t6_onehot_low", bad_shape, 0);
        check("t6_dwell_len", bad_len, 0);
        check("t6_col_order", bad_order, 0);
        check("t6_transitions", trans, 250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
